// File: rtl/hazard_fwd_ctrl_if.sv
// Pipeline-to-hazard-controller bus: ID/EX instruction info in, stall/flush/forward controls out.
interface hazard_fwd_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_jump;
  logic              ex_branch_taken;
  logic              stall;
  logic              bubble_ex;
  logic              flush_if_id;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // Pipeline side: supplies instruction info, consumes the control decisions
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_reg_write, id_mem_read, id_jump, ex_branch_taken,
    input  stall, bubble_ex, flush_if_id, fwd_a_sel, fwd_b_sel,
           stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_reg_write, id_mem_read, id_jump, ex_branch_taken,
    output stall, bubble_ex, flush_if_id, fwd_a_sel, fwd_b_sel,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Central hazard/forwarding controller for a 5-stage pipeline. A shadow
// scoreboard of the EX/DM/WB destinations drives load-use and RAW stalls,
// branch/jump flushes, registered EX forwarding selects and saturating
// stall/flush counters.
module hazard_fwd_ctrl #(
  parameter int REG_AW     = 5,
  parameter int FWD_EN     = 1,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  hazard_fwd_ctrl_if.slave bus
);
  localparam int NSLOT = 3;
  localparam int EX    = 0;
  localparam int DM    = 1;
  localparam int WB    = 2;
  // Only EX and DM can cause a hazard; WB is covered by write-before-read.
  localparam int NHZ   = 2;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              mr;
  } slot_t;

  slot_t            slot_q [NSLOT];
  slot_t            slot_d [NSLOT];
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [NHZ-1:0]   wr_rs;
  logic [NHZ-1:0]   wr_rt;
  logic [NHZ-1:0]   src_hit;
  logic             hz;
  logic             stall_c;
  logic             bubble_c;
  logic             flush_c;

  // Per-slot "is writing the register ID reads" matches; r0 never matches.
  generate
    for (genvar gi = 0; gi < NHZ; gi++) begin : g_match
      assign wr_rs[gi]   = slot_q[gi].v & slot_q[gi].rw &
                           (slot_q[gi].rd == bus.id_rs) & (slot_q[gi].rd != '0);
      assign wr_rt[gi]   = slot_q[gi].v & slot_q[gi].rw &
                           (slot_q[gi].rd == bus.id_rt) & (slot_q[gi].rd != '0);
      assign src_hit[gi] = (bus.id_uses_rs & wr_rs[gi]) | (bus.id_uses_rt & wr_rt[gi]);
    end
  endgenerate

  // Hazard window: loads only when forwarding, every producer in EX/DM otherwise.
  generate
    if (FWD_EN != 0) begin : g_hz_fwd
      if (LOAD_STALL == 2) begin : g_ls2
        assign hz = (slot_q[EX].mr & src_hit[EX]) | (slot_q[DM].mr & src_hit[DM]);
      end else begin : g_ls1
        assign hz = slot_q[EX].mr & src_hit[EX];
      end
    end else begin : g_hz_nofwd
      assign hz = src_hit[EX] | src_hit[DM];
    end
  endgenerate

  // The WB slot is a pure shadow of the retiring instruction, and some match
  // bits go unread depending on the configuration.
  logic unused_bits;
  assign unused_bits = ^{slot_q[WB], src_hit, wr_rs, wr_rt};

  // Same-cycle control decisions; a taken branch overrides any stall.
  always_comb begin
    stall_c  = bus.id_valid & hz & ~bus.ex_branch_taken;
    bubble_c = stall_c | bus.ex_branch_taken;
    flush_c  = bus.ex_branch_taken | (bus.id_valid & bus.id_jump & ~stall_c);
  end

  // Combinational controls are held quiet for as long as reset is asserted.
  assign bus.stall       = reset & stall_c;
  assign bus.bubble_ex   = reset & bubble_c;
  assign bus.flush_if_id = reset & flush_c;
  assign bus.fwd_a_sel   = fwd_a_q;
  assign bus.fwd_b_sel   = fwd_b_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

  // Scoreboard shift, forwarding selects for the instruction entering EX, counters.
  always_comb begin
    slot_d[WB]  = slot_q[DM];
    slot_d[DM]  = slot_q[EX];
    slot_d[EX]  = '0;
    fwd_a_d     = 2'b00;
    fwd_b_d     = 2'b00;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (!bubble_c && bus.id_valid) begin
      slot_d[EX] = {1'b1, bus.id_rd, bus.id_reg_write, bus.id_mem_read};
    end

    // Newest producer wins: EX/DM ALU result before DM/WB write data.
    if ((FWD_EN != 0) && !bubble_c) begin
      if (wr_rs[EX] && !slot_q[EX].mr) begin
        fwd_a_d = 2'b10;
      end else if (wr_rs[DM]) begin
        fwd_a_d = 2'b01;
      end
      if (wr_rt[EX] && !slot_q[EX].mr) begin
        fwd_b_d = 2'b10;
      end else if (wr_rt[DM]) begin
        fwd_b_d = 2'b01;
      end
    end

    if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_c && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset to an empty pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        slot_q[i] <= '0;
      end
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        slot_q[i] <= slot_d[i];
      end
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule
